// File: rtl/baopoco_quant_gain_apply.sv
`default_nettype none
// ============================================================================
// Module   : baopoco_quant_gain_apply
// Purpose  : Applies the software quantiser gain to the complex FFT output
//            stream. Each sample is scaled, rounded half-up and saturated
//            symmetrically to a 4+4-bit complex word. The gain only changes
//            at spectrum boundaries, and the number of clipped samples in
//            each spectrum is reported back.
// Ports    : user_clk   - sole clock, rising edge
//            user_rst   - synchronous active-high reset
//            gain_reg   - gain register word, [GAIN_WIDTH-1:0] used
//            sync_in    - pulse one cycle before the first sample of a spectrum
//            valid_in   - din qualifier
//            din_re/im  - signed input components
//            sync_out   - sync_in delayed by the pipeline latency (4)
//            valid_out  - valid_in delayed by the pipeline latency (4)
//            dout       - {re, im}, each signed DOUT_WIDTH bits, re in MSBs
//            clip_count - clipped-sample count of the previous spectrum
// Revision : 1.0 - initial release
// ============================================================================
module baopoco_quant_gain_apply #(
  parameter int DIN_WIDTH  = 18,
  parameter int GAIN_WIDTH = 16,
  parameter int GAIN_FRAC  = 10,
  parameter int DOUT_WIDTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         user_clk,
  input  logic                         user_rst,
  input  logic [31:0]                  gain_reg,
  input  logic                         sync_in,
  input  logic                         valid_in,
  input  logic signed [DIN_WIDTH-1:0]  din_re,
  input  logic signed [DIN_WIDTH-1:0]  din_im,
  output logic                         sync_out,
  output logic                         valid_out,
  output logic [2*DOUT_WIDTH-1:0]      dout,
  output logic [CNT_WIDTH-1:0]         clip_count
);

  // Product width and position of its binary point.
  localparam int c_PROD_W = DIN_WIDTH + GAIN_WIDTH;
  localparam int c_SUM_W  = c_PROD_W + 1;
  localparam int c_BP     = DIN_WIDTH - 1 + GAIN_FRAC;
  localparam int c_SHIFT  = c_BP - (DOUT_WIDTH - 1);

  localparam logic signed [c_SUM_W-1:0] c_RND  = c_SUM_W'(1) << (c_SHIFT - 1);
  localparam logic signed [c_SUM_W-1:0] c_QMAX = c_SUM_W'((1 << (DOUT_WIDTH - 1)) - 1);
  // Symmetric range: the most negative code is never produced.
  localparam logic signed [c_SUM_W-1:0] c_QMIN = -c_QMAX;

  // Only the low GAIN_WIDTH bits of the register word carry the gain.
  if (GAIN_WIDTH < 32) begin : g_gain_unused
    logic w_unused_gain;
    assign w_unused_gain = ^gain_reg[31:GAIN_WIDTH];
  end

  // Round half-up, arithmetic shift, symmetric saturate. Returns {clip, value}.
  function automatic logic [DOUT_WIDTH:0] f_quant(input logic signed [c_PROD_W-1:0] prod);
    logic signed [c_SUM_W-1:0] sum;
    logic signed [c_SUM_W-1:0] shifted;
    logic [DOUT_WIDTH:0]       res;
    // One extra bit of headroom so the rounding constant can never wrap.
    sum     = {prod[c_PROD_W-1], prod} + c_RND;
    shifted = sum >>> c_SHIFT;
    if (shifted > c_QMAX) begin
      res = {1'b1, c_QMAX[DOUT_WIDTH-1:0]};
    end else if (shifted < c_QMIN) begin
      res = {1'b1, c_QMIN[DOUT_WIDTH-1:0]};
    end else begin
      res = {1'b0, shifted[DOUT_WIDTH-1:0]};
    end
    return res;
  endfunction

  // Gain in force for the current spectrum.
  logic [GAIN_WIDTH-1:0]        gain_active_q;

  // S1: registered inputs plus the gain that applies to this sample.
  logic                         s1_sync_q, s1_valid_q;
  logic signed [DIN_WIDTH-1:0]  s1_re_q, s1_im_q;
  logic [GAIN_WIDTH-1:0]        s1_gain_q;

  // S2: full-precision products.
  logic                         s2_sync_q, s2_valid_q;
  logic signed [c_PROD_W-1:0]   s2_re_q, s2_im_q, s2_re_d, s2_im_d;

  // S3: quantised components and clip flag.
  logic                         s3_sync_q, s3_valid_q, s3_clip_q, s3_clip_d;
  logic [DOUT_WIDTH-1:0]        s3_re_q, s3_im_q, s3_re_d, s3_im_d;

  // Clip statistics.
  logic [CNT_WIDTH-1:0]         running_q, running_d, clip_count_d;
  logic [CNT_WIDTH-1:0]         w_run_next;

  logic signed [c_PROD_W-1:0]   w_re_ext, w_im_ext, w_gain_ext;
  logic [DOUT_WIDTH:0]          w_q_re, w_q_im;

  // Operands widened to the product width so the multiply is exact.
  assign w_re_ext   = {{(c_PROD_W-DIN_WIDTH){s1_re_q[DIN_WIDTH-1]}}, s1_re_q};
  assign w_im_ext   = {{(c_PROD_W-DIN_WIDTH){s1_im_q[DIN_WIDTH-1]}}, s1_im_q};
  assign w_gain_ext = {{(c_PROD_W-GAIN_WIDTH){1'b0}}, s1_gain_q};

  assign w_q_re = f_quant(s2_re_q);
  assign w_q_im = f_quant(s2_im_q);

  always_comb begin
    s2_re_d   = w_re_ext * w_gain_ext;
    s2_im_d   = w_im_ext * w_gain_ext;
    s3_re_d   = w_q_re[DOUT_WIDTH-1:0];
    s3_im_d   = w_q_im[DOUT_WIDTH-1:0];
    // Invalid slots never contribute to the statistics.
    s3_clip_d = s2_valid_q & (w_q_re[DOUT_WIDTH] | w_q_im[DOUT_WIDTH]);
  end

  // Saturating count, including the sample leaving S3 this cycle.
  always_comb begin
    w_run_next   = running_q;
    if (s3_clip_q && (running_q != {CNT_WIDTH{1'b1}})) begin
      w_run_next = running_q + CNT_WIDTH'(1);
    end
    running_d    = w_run_next;
    clip_count_d = clip_count;
    // Publish on the cycle sync_out rises and restart the running count.
    if (s3_sync_q) begin
      clip_count_d = w_run_next;
      running_d    = '0;
    end
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      gain_active_q <= gain_reg[GAIN_WIDTH-1:0];
      s1_sync_q     <= 1'b0;
      s1_valid_q    <= 1'b0;
      s1_re_q       <= '0;
      s1_im_q       <= '0;
      s1_gain_q     <= '0;
      s2_sync_q     <= 1'b0;
      s2_valid_q    <= 1'b0;
      s2_re_q       <= '0;
      s2_im_q       <= '0;
      s3_sync_q     <= 1'b0;
      s3_valid_q    <= 1'b0;
      s3_clip_q     <= 1'b0;
      s3_re_q       <= '0;
      s3_im_q       <= '0;
      sync_out      <= 1'b0;
      valid_out     <= 1'b0;
      dout          <= '0;
      running_q     <= '0;
      clip_count    <= '0;
    end else begin
      // A sample arriving with sync_in still picks up the old gain, since
      // S1 samples gain_active_q before it is overwritten.
      if (sync_in) begin
        gain_active_q <= gain_reg[GAIN_WIDTH-1:0];
      end
      s1_sync_q  <= sync_in;
      s1_valid_q <= valid_in;
      s1_re_q    <= din_re;
      s1_im_q    <= din_im;
      s1_gain_q  <= gain_active_q;

      s2_sync_q  <= s1_sync_q;
      s2_valid_q <= s1_valid_q;
      s2_re_q    <= s2_re_d;
      s2_im_q    <= s2_im_d;

      s3_sync_q  <= s2_sync_q;
      s3_valid_q <= s2_valid_q;
      s3_clip_q  <= s3_clip_d;
      s3_re_q    <= s3_re_d;
      s3_im_q    <= s3_im_d;

      sync_out   <= s3_sync_q;
      valid_out  <= s3_valid_q;
      dout       <= {s3_re_q, s3_im_q};

      running_q  <= running_d;
      clip_count <= clip_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_baopoco_quant_gain_apply.sv
`default_nettype none
// ============================================================================
// Module   : tb_baopoco_quant_gain_apply
// Purpose  : Directed-vector scoreboard bench for baopoco_quant_gain_apply.
//            The driver pushes the hand-computed output word and its arrival
//            cycle; a negedge monitor pops and compares on valid_out/sync_out.
// Revision : 1.0 - initial release
// ============================================================================
module tb_baopoco_quant_gain_apply;

  logic               user_clk = 1'b0;
  logic               user_rst;
  logic [31:0]        gain_reg;
  logic               sync_in;
  logic               valid_in;
  logic signed [17:0] din_re;
  logic signed [17:0] din_im;
  logic               sync_out;
  logic               valid_out;
  logic [7:0]         dout;
  logic [15:0]        clip_count;

  baopoco_quant_gain_apply dut (
    .user_clk   (user_clk),
    .user_rst   (user_rst),
    .gain_reg   (gain_reg),
    .sync_in    (sync_in),
    .valid_in   (valid_in),
    .din_re     (din_re),
    .din_im     (din_im),
    .sync_out   (sync_out),
    .valid_out  (valid_out),
    .dout       (dout),
    .clip_count (clip_count)
  );

  always #5 user_clk = ~user_clk;

  int cyc = 0;
  always @(posedge user_clk) cyc <= cyc + 1;

  typedef struct {
    int          c;
    logic [15:0] v;
  } exp_t;

  exp_t data_q[$];
  exp_t sync_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic signed [17:0] c_P25  = 18'sd32768;    // +0.25
  localparam logic signed [17:0] c_NEG1 = 18'sh20000;    // -1.0 (most negative)

  // Monitor: compare every presented output against the scoreboard.
  always @(negedge user_clk) begin
    exp_t e;
    if (!user_rst) begin
      if (data_q.size() > 0 && data_q[0].c < cyc) begin
        e = data_q.pop_front();
        total++;
        bad++;
        $display("FAIL dout: no valid_out at cycle %0d, expected dout=%h", e.c, e.v[7:0]);
      end
      if (sync_q.size() > 0 && sync_q[0].c < cyc) begin
        e = sync_q.pop_front();
        total++;
        bad++;
        $display("FAIL clip_count: no sync_out at cycle %0d, expected clip_count=%h", e.c, e.v);
      end
      if (valid_out) begin
        total++;
        if (data_q.size() == 0) begin
          bad++;
          $display("FAIL dout: unexpected valid_out at cycle %0d dout=%h", cyc, dout);
        end else begin
          e = data_q.pop_front();
          if (e.c != cyc || e.v[7:0] !== dout) begin
            bad++;
            $display("FAIL dout: got %h at cycle %0d, expected %h at cycle %0d",
                     dout, cyc, e.v[7:0], e.c);
          end
        end
      end
      if (sync_out) begin
        total++;
        if (sync_q.size() == 0) begin
          bad++;
          $display("FAIL clip_count: unexpected sync_out at cycle %0d clip_count=%h", cyc, clip_count);
        end else begin
          e = sync_q.pop_front();
          if (e.c != cyc || e.v !== clip_count) begin
            bad++;
            $display("FAIL clip_count: got %h at cycle %0d, expected %h at cycle %0d",
                     clip_count, cyc, e.v, e.c);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // One input cycle; output is due 4 clock edges after the sampling edge.
  task automatic send(input logic s, input logic v,
                      input logic signed [17:0] re, input logic signed [17:0] im,
                      input logic [7:0] ed, input logic [15:0] ec);
    sync_in  = s;
    valid_in = v;
    din_re   = re;
    din_im   = im;
    if (v) data_q.push_back('{cyc + 4, {8'h00, ed}});
    if (s) sync_q.push_back('{cyc + 4, ec});
    @(posedge user_clk);
    #1;
    sync_in  = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) send(1'b0, 1'b0, 18'sd0, 18'sd0, 8'h00, 16'h0000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    user_rst = 1'b1;
    gain_reg = 32'hABCD_0400;   // upper bits must be ignored
    sync_in  = 1'b0;
    valid_in = 1'b0;
    din_re   = '0;
    din_im   = '0;
    repeat (3) @(posedge user_clk);
    #1;
    user_rst = 1'b0;
    chk("reset sync_out",   {15'd0, sync_out},  16'h0000);
    chk("reset valid_out",  {15'd0, valid_out}, 16'h0000);
    chk("reset dout",       {8'd0, dout},       16'h0000);
    chk("reset clip_count", clip_count,         16'h0000);

    // Gain 1.0: basic scaling, rounding and symmetric saturation.
    send(1, 0, 18'sd0, 18'sd0, 8'h00, 16'd0);
    send(0, 1, c_P25, -c_P25, 8'h2E, 16'd0);
    send(0, 1, 18'sd8192, 18'sd0, 8'h10, 16'd0);
    send(0, 1, -18'sd8192, 18'sd0, 8'h00, 16'd0);
    send(0, 1, 18'sd12288, 18'sd0, 8'h10, 16'd0);
    send(0, 1, 18'sd131071, 18'sd0, 8'h70, 16'd0);
    send(0, 1, c_NEG1, c_NEG1, 8'h99, 16'd0);

    // Gain 4.0: three clipping samples, both components saturate.
    gain_reg = 32'h0000_1000;
    send(1, 0, 18'sd0, 18'sd0, 8'h00, 16'd2);
    repeat (3) send(0, 1, c_P25, c_NEG1, 8'h79, 16'd0);

    // Gain latch timing: mid-spectrum change has no effect until next sync.
    gain_reg = 32'h0000_0400;
    send(1, 0, 18'sd0, 18'sd0, 8'h00, 16'd3);
    send(0, 1, c_P25, 18'sd0, 8'h20, 16'd0);
    gain_reg = 32'h0000_0800;
    send(0, 1, c_P25, 18'sd0, 8'h20, 16'd0);
    send(1, 1, c_P25, 18'sd0, 8'h20, 16'd0);
    send(0, 1, c_P25, 18'sd0, 8'h40, 16'd0);

    // Back-to-back syncs, then valid gaps 1010 with clipping data.
    gain_reg = 32'h0000_1000;
    send(1, 0, 18'sd0, 18'sd0, 8'h00, 16'd0);
    send(1, 0, 18'sd0, 18'sd0, 8'h00, 16'd0);
    send(0, 1, c_P25, c_NEG1, 8'h79, 16'd0);
    send(0, 0, c_P25, c_NEG1, 8'h00, 16'd0);
    send(0, 1, c_P25, c_NEG1, 8'h79, 16'd0);
    send(0, 0, c_P25, c_NEG1, 8'h00, 16'd0);
    send(1, 0, 18'sd0, 18'sd0, 8'h00, 16'd2);

    // Clip in the sync cycle itself is included in the published count.
    send(0, 1, c_P25, c_NEG1, 8'h79, 16'd0);
    send(1, 1, c_P25, c_NEG1, 8'h79, 16'd2);

    // Counter saturation at all-ones.
    repeat (70000) send(0, 1, c_P25, c_NEG1, 8'h79, 16'd0);
    send(1, 0, 18'sd0, 18'sd0, 8'h00, 16'hFFFF);
    idle(6);

    // Mid-spectrum reset: two clips complete, three more in flight.
    send(0, 1, c_P25, c_NEG1, 8'h79, 16'd0);
    send(0, 1, c_P25, c_NEG1, 8'h79, 16'd0);
    idle(5);
    gain_reg = 32'h0000_0800;
    repeat (3) send(0, 1, c_P25, c_NEG1, 8'h79, 16'd0);
    user_rst = 1'b1;
    data_q.delete();
    sync_q.delete();
    @(posedge user_clk);
    #1;
    user_rst = 1'b0;
    chk("post-reset clip_count", clip_count,        16'h0000);
    chk("post-reset sync_out",   {15'd0, sync_out}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      chk("post-reset valid_out", {15'd0, valid_out}, 16'h0000);
      @(posedge user_clk);
      #1;
    end
    // Gain reloaded from gain_reg during reset (2.0); running count cleared.
    send(0, 1, c_P25, 18'sd0, 8'h40, 16'd0);
    send(1, 0, 18'sd0, 18'sd0, 8'h00, 16'd0);

    for (int i = 0; i < 20 && (data_q.size() > 0 || sync_q.size() > 0); i++) begin
      @(posedge user_clk);
      #1;
    end
    if (data_q.size() > 0 || sync_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d data and %0d sync expectations never observed, required 0",
               data_q.size(), sync_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
